priority_encoder_rr: RTL

//  Parametrised, registered N-to-log2(N) priority encoder with valid/ready handshakes.
//  Two modes, selectable at run time:
//   - fixed priority: highest index wins
//   - round-robin: a fair grant rotation

---
 rtl/priority_encoder_rr_if.sv | 29 ++
 rtl/priority_encoder_rr.sv | 81 ++++++++
 2 files changed

// File: rtl/priority_encoder_rr_if.sv
// Request/result bundle for priority_encoder_rr: request side plus registered result side.
interface priority_encoder_rr_if #(
  parameter int unsigned N = 8
) ();
  localparam int unsigned W = $clog2(N);

  logic         mode;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] req;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic         out_any;
  logic         out_multi;

  // Producer of requests and consumer of results.
  modport master (
    output mode, in_valid, req, out_ready,
    input  in_ready, out_valid, out_idx, out_onehot, out_any, out_multi
  );

  // The encoder itself.
  modport slave (
    input  mode, in_valid, req, out_ready,
    output in_ready, out_valid, out_idx, out_onehot, out_any, out_multi
  );
endinterface

// File: rtl/priority_encoder_rr.sv
// Registered N-to-log2(N) priority encoder, fixed (MSB wins) or round-robin, with a
// single-entry output register behind a valid/ready handshake.
module priority_encoder_rr #(
  parameter int unsigned N = 8
) (
  input logic                clk,
  input logic                rst,
  priority_encoder_rr_if.slave bus
);
  localparam int unsigned W = $clog2(N);

  logic [W-1:0] last_q;
  logic         valid_q;
  logic [W-1:0] idx_q;
  logic [N-1:0] onehot_q;
  logic         any_q;
  logic         multi_q;

  logic         accept;
  logic [W-1:0] win;
  logic         any_d;
  logic         multi_d;
  logic [N-1:0] onehot_d;

  // Single-entry buffer: free when empty or being drained this cycle.
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Winner selection; req == 0 leaves win at 0 in both modes.
  always_comb begin
    int p;
    win = '0;
    p   = 0;
    if (!bus.mode) begin
      for (int i = 0; i < int'(N); i++) begin
        if (bus.req[i]) win = W'(i);
      end
    end else begin
      // Walk the rotation backwards so the earliest position after last_q is written last.
      for (int k = int'(N); k >= 1; k--) begin
        p = int'(last_q) + k;
        if (p >= int'(N)) p = p - int'(N);
        if (bus.req[p]) win = W'(p);
      end
    end
  end

  // Summary flags and one-hot grant for the candidate result.
  always_comb begin
    any_d    = |bus.req;
    multi_d  = |(bus.req & (bus.req - N'(1)));
    onehot_d = any_d ? (N'(1) << win) : '0;
  end

  // Result registers and round-robin pointer; everything frozen while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      any_q    <= 1'b0;
      multi_q  <= 1'b0;
      last_q   <= W'(N - 1);
    end else if (accept) begin
      valid_q  <= 1'b1;
      idx_q    <= win;
      onehot_q <= onehot_d;
      any_q    <= any_d;
      multi_q  <= multi_d;
      if (bus.mode && any_d) last_q <= win;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_idx    = idx_q;
  assign bus.out_onehot = onehot_q;
  assign bus.out_any    = any_q;
  assign bus.out_multi  = multi_q;
endmodule
